// File: rtl/mem_stall_unit.sv
// mem_stall_unit
// MEM-stage data-memory access controller. Turns the one-cycle MemRead /
// MemWrite controls held in EX/MEM into a req/ack transaction on a
// variable-latency memory port and freezes the pipeline until the memory
// answers. Captured load data is handed to MEM/WB in the DONE cycle.

module mem_stall_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              EX_MEM_MemRead_i,
   input  logic              EX_MEM_MemWrite_i,
   input  logic [ADDR_W-1:0] EX_MEM_addr_i,
   input  logic [DATA_W-1:0] EX_MEM_wdata_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              stall_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic              req_q,   req_d;
   logic              we_q,    we_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;

   logic access;
   logic stall;
   logic issue;
   logic complete;

   assign access = EX_MEM_MemRead_i | EX_MEM_MemWrite_i;

   // State register; reset drops any in-flight transaction back to IDLE
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: IDLE issues, WAIT holds until ack, DONE always retires
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (access)    state_d = ST_WAIT;
         ST_WAIT: if (mem_ack_i) state_d = ST_DONE;
         ST_DONE:                state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // Output decode: stall covers the issuing IDLE cycle and every WAIT cycle
   always_comb begin
      stall    = 1'b0;
      issue    = 1'b0;
      complete = 1'b0;
      case (state_q)
         ST_IDLE: begin
            stall = access;
            issue = access;
         end
         ST_WAIT: begin
            stall    = 1'b1;
            complete = mem_ack_i;
         end
         default: begin
            stall    = 1'b0;
         end
      endcase
   end

   // Datapath next values: latch the request on issue, capture load data on
   // completion, and count stalled edges with saturation at all-ones
   always_comb begin
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      if (issue) begin
         req_d   = 1'b1;
         we_d    = EX_MEM_MemWrite_i & ~EX_MEM_MemRead_i;
         addr_d  = EX_MEM_addr_i;
         wdata_d = EX_MEM_wdata_i;
      end
      if (complete) begin
         req_d = 1'b0;
         if (!we_q) begin
            rdata_d = mem_rdata_i;
         end
      end
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Datapath registers, all cleared asynchronously
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_req_o   = req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign rdata_o     = rdata_q;
   assign stall_o     = stall;
   assign stall_cnt_o = cnt_q;

endmodule
